// File: rtl/mul_issue_sequencer_pkg.sv
// mul_issue_sequencer_pkg: ALU control codes, FSM states and counter width shared by the MUL sequencer
package mul_issue_sequencer_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_MUL = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_issue_sequencer_counter.sv
// mul_latency_counter: loadable down-counter with zero flag pacing the multiply latency
module mul_latency_counter
    import mul_issue_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_dec)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mul_issue_sequencer.sv
// mul_issue_sequencer: execute-stage controller for the fixed-latency MUL path with stall and result hold
module mul_issue_sequencer
    import mul_issue_sequencer_pkg::*;
#(
    parameter int MUL_LATENCY = 4,
    parameter int DATA_W      = 32,
    parameter int REG_W       = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [1:0]        alu_ctrl_in,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic [REG_W-1:0]  dest_in,
    input  logic              flush,
    input  logic              hold_in,
    output logic              stall_out,
    output logic              busy,
    output logic              result_valid,
    output logic [DATA_W-1:0] result,
    output logic [REG_W-1:0]  result_dest
);

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [REG_W-1:0]  r_dest;
    logic [DATA_W-1:0] r_result;
    logic [REG_W-1:0]  r_result_dest;
    logic [DATA_W-1:0] w_product;
    logic              w_accept;
    logic              w_zero;
    logic              w_finish;

    assign w_accept  = valid_in && alu_ctrl_in == ALU_MUL && r_state == S_IDLE && !flush;
    assign w_finish  = r_state == S_BUSY && w_zero;
    // Low DATA_W bits of the product are the same for signed and unsigned operands
    assign w_product = r_a * r_b;

    mul_latency_counter u_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_accept),
        .i_load_val (CNT_W'(MUL_LATENCY - 2)),
        .i_dec      (r_state == S_BUSY && !w_zero),
        .o_zero     (w_zero)
    );

    always_comb begin
        w_next    = r_state;
        w_next    = flush                               ? S_IDLE :
                    w_accept                            ? S_BUSY :
                    w_finish                            ? S_DONE :
                    (r_state == S_DONE && !hold_in)     ? S_IDLE : r_state;
        stall_out = !flush && (w_accept || r_state == S_BUSY || (r_state == S_DONE && hold_in));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_a           <= '0;
            r_b           <= '0;
            r_dest        <= '0;
            r_result      <= '0;
            r_result_dest <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a    <= src_a;
                r_b    <= src_b;
                r_dest <= dest_in;
            end
            if (w_finish && !flush) begin
                r_result      <= w_product;
                r_result_dest <= r_dest;
            end
        end
    end

    assign busy         = r_state != S_IDLE;
    assign result_valid = r_state == S_DONE;
    assign result       = r_result;
    assign result_dest  = r_result_dest;

endmodule

// File: tb/tb_mul_issue_sequencer.sv
// tb_mul_issue_sequencer: directed and random stimulus checked against a cycle-indexed transaction model
module tb_mul_issue_sequencer;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic [1:0]  alu_ctrl_in = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic [4:0]  dest_in = '0;
    logic        flush = 1'b0;
    logic        hold_in = 1'b0;
    logic        stall_out;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;
    logic [4:0]  result_dest;

    int checks = 0;
    int errors = 0;

    // Model: one outstanding job, its result due at an absolute cycle number
    bit          m_sync = 0;
    bit          m_job = 0;
    int          m_ready = 0;
    int          cyc = 0;
    logic [31:0] m_res = '0;
    logic [4:0]  m_dest = '0;

    mul_issue_sequencer #(.MUL_LATENCY(L), .DATA_W(32), .REG_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .alu_ctrl_in  (alu_ctrl_in),
        .src_a        (src_a),
        .src_b        (src_b),
        .dest_in      (dest_in),
        .flush        (flush),
        .hold_in      (hold_in),
        .stall_out    (stall_out),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .result_dest  (result_dest)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input logic f, input logic h, input logic r);
        logic        acc;
        logic        mv;
        logic        ms;
        logic [63:0] full;
        @(posedge clk);
        #1;
        valid_in = v; alu_ctrl_in = c; src_a = a; src_b = b; dest_in = d;
        flush = f; hold_in = h; reset = r;
        @(negedge clk);
        mv  = m_job && cyc >= m_ready;
        acc = v && c == 2'b01 && !m_job && !f;
        ms  = !f && (acc || (m_job && cyc < m_ready) || (mv && h));
        if (m_sync) begin
            check("stall_out", {31'd0, stall_out}, {31'd0, ms});
            check("busy", {31'd0, busy}, {31'd0, m_job});
            check("result_valid", {31'd0, result_valid}, {31'd0, mv});
            if (mv) begin
                check("result", result, m_res);
                check("result_dest", {27'd0, result_dest}, {27'd0, m_dest});
            end
        end
        if (r) begin
            m_job = 0; m_sync = 1;
        end else if (f) begin
            m_job = 0;
        end else if (acc) begin
            full    = {32'd0, a} * {32'd0, b};
            m_job   = 1;
            m_ready = cyc + L;
            m_res   = full[31:0];
            m_dest  = d;
        end else if (mv && !h) begin
            m_job = 0;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 2'b00, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
        step(1, 2'b01, a, b, d, 0, 0, 0);
    endtask

    initial begin
        step(0, 2'b00, 0, 0, 0, 0, 0, 1);
        step(0, 2'b00, 0, 0, 0, 0, 0, 1);
        idle(1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, result_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_dest", {27'd0, result_dest}, 32'd0);

        // Basic 7*6
        mul(7, 6, 3);
        check("basic_stall_T", {31'd0, stall_out}, 32'd1);
        idle(3);
        check("basic_stall_T3", {31'd0, stall_out}, 32'd1);
        idle(1);
        check("basic_valid", {31'd0, result_valid}, 32'd1);
        check("basic_result", result, 32'd42);
        check("basic_dest", {27'd0, result_dest}, 32'd3);
        check("basic_stall_T4", {31'd0, stall_out}, 32'd0);
        idle(1);
        check("basic_idle", {31'd0, busy}, 32'd0);

        // Truncation
        mul(32'hFFFF_FFFF, 2, 7);
        idle(4);
        check("trunc_a", result, 32'hFFFF_FFFE);
        idle(1);
        mul(32'h0001_0000, 32'h0001_0000, 8);
        idle(4);
        check("trunc_b", result, 32'd0);
        check("trunc_b_valid", {31'd0, result_valid}, 32'd1);
        idle(1);

        // Backpressure
        mul(7, 6, 9);
        idle(2);
        for (int i = 0; i < 5; i++) step(0, 2'b00, 0, 0, 0, 0, 1, 0);
        check("bp_valid", {31'd0, result_valid}, 32'd1);
        check("bp_result", result, 32'd42);
        check("bp_stall", {31'd0, stall_out}, 32'd1);
        idle(1);
        check("bp_release_stall", {31'd0, stall_out}, 32'd0);
        idle(1);
        check("bp_idle", {31'd0, busy}, 32'd0);

        // Flush mid-operation and flush against an issuing MUL
        mul(11, 13, 4);
        idle(1);
        step(0, 2'b00, 0, 0, 0, 1, 0, 0);
        check("flush_stall", {31'd0, stall_out}, 32'd0);
        idle(1);
        check("flush_busy", {31'd0, busy}, 32'd0);
        idle(7);
        check("flush_novalid", {31'd0, result_valid}, 32'd0);
        step(1, 2'b01, 3, 3, 1, 1, 0, 0);
        check("flush_acc_stall", {31'd0, stall_out}, 32'd0);
        idle(1);
        check("flush_acc_busy", {31'd0, busy}, 32'd0);

        // Non-MUL codes
        step(1, 2'b00, 1, 2, 1, 0, 0, 0);
        check("add_stall", {31'd0, stall_out}, 32'd0);
        step(1, 2'b10, 1, 2, 1, 0, 0, 0);
        check("sub_stall", {31'd0, stall_out}, 32'd0);
        idle(1);
        check("nonmul_busy", {31'd0, busy}, 32'd0);

        // Back-to-back: second MUL held by decode until the first retires
        mul(5, 5, 1);
        for (int i = 0; i < 5; i++) begin
            mul(3, 4, 2);
            if (i == 3) check("b2b_first", result, 32'd25);
        end
        idle(3);
        idle(1);
        check("b2b_second", result, 32'd12);
        check("b2b_second_dest", {27'd0, result_dest}, 32'd2);
        idle(1);

        // Reset mid-operation
        mul(9, 9, 4);
        idle(1);
        step(0, 2'b00, 0, 0, 0, 0, 0, 1);
        idle(1);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_valid", {31'd0, result_valid}, 32'd0);
        check("mrst_result", result, 32'd0);
        check("mrst_dest", {27'd0, result_dest}, 32'd0);
        check("mrst_stall", {31'd0, stall_out}, 32'd0);
        mul(2, 3, 5);
        idle(3);
        idle(1);
        check("mrst_new_result", result, 32'd6);
        check("mrst_new_dest", {27'd0, result_dest}, 32'd5);
        idle(1);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            logic       v;
            logic [1:0] c;
            v = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
            step(v, c, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom,
                 5'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
